fetch_ctrl: RTL

//  PC sequencer for the combinational instruction memory (fetch). Drives the word-aligned fetch

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 83 ++++++++
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch controller.
//   RESET_PC_DEFAULT : default first fetch address after reset (word aligned)
//   fetch_state_e    : fetch controller state (RUN, HALT, FAULT)
//   fetch_entry_t    : one queued fetch result, {pc, ir}
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, ir} pairs between fetch and decode.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push         : write push_entry (ignored when full unless popping the same cycle)
//   push_entry   : entry to write
//   pop          : drop head entry (ignored when empty)
//   flush        : discard all entries; wins over push and pop
//   head         : registered head entry (storage clears to zero on reset)
//   count        : number of valid entries
//   full, empty  : occupancy flags
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_entry_t    mem_q [QDEPTH];
    fetch_entry_t    mem_d [QDEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop, do_push;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A full queue accepts a push only when the head leaves the same cycle.
        do_push  = push && ((count_q != CW'(QDEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(QDEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer for the combinational instruction memory. Owns the fetch PC,
// queues {pc, ir} pairs and hands them to decode over valid/ready.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : word-aligned fetch address (equals the fetch PC)
//   imem_data       : instruction at imem_addr, same cycle
//   redirect_valid  : execute requests a PC change this cycle
//   redirect_pc     : new fetch target (low two bits dropped)
//   halt            : level; no new fetches while high
//   out_valid/ready : decode handshake; an entry transfers on a cycle where both
//                     are high and no redirect is flushing the queue
//   out_pc, out_ir  : head entry
//   misalign        : sticky, a redirect target had nonzero low bits
//   fault           : sticky, the fetch PC left instruction memory
//   dbg_state       : current controller state
//   dbg_count       : current queue occupancy
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 32768,
    parameter int          QDEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_data,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    input  logic                         halt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_ir,
    output logic                         misalign,
    output logic                         fault,
    output fetch_state_e                 dbg_state,
    output logic [$clog2(QDEPTH+1)-1:0]  dbg_count
);

    localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          misalign_q, misalign_d;
    logic          fault_q, fault_d;

    logic          redirect, in_range, pop, do_push;
    logic          q_full, q_empty;
    fetch_entry_t  q_head, q_push_entry;

    // FAULT is terminal: redirects are ignored there.
    assign redirect = redirect_valid && (state_q != ST_FAULT);
    assign in_range = ({2'b00, fetch_pc_q[31:2]} < IMEM_WORDS_W);
    assign pop      = !q_empty && out_ready;

    always_comb begin
        do_push      = (state_q == ST_RUN) && !halt && !redirect && in_range
                       && (!q_full || pop);
        q_push_entry = '{pc: fetch_pc_q, ir: imem_data};

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (do_push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;   // wraps mod 2^32
        end

        state_d = state_q;
        if (state_q != ST_FAULT) begin
            if (!redirect && !in_range) begin
                state_d = ST_FAULT;
            end else if (halt) begin
                state_d = ST_HALT;
            end else begin
                state_d = ST_RUN;
            end
        end

        misalign_d = misalign_q || (redirect && (redirect_pc[1:0] != 2'b00));
        fault_d    = fault_q || ((state_q != ST_FAULT) && !redirect && !in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    // Redirect flushes everything, including a head that decode is accepting.
    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (do_push),
        .push_entry (q_push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (q_head),
        .count      (dbg_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    assign imem_addr = fetch_pc_q;
    assign out_valid = !q_empty;
    assign out_pc    = q_head.pc;
    assign out_ir    = q_head.ir;
    assign misalign  = misalign_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule
